// File: rtl/dec_to_gray_enc.sv
// Decimal (10-line one-hot) to 4-bit Gray encoder with a one-deep valid/ready
// output register, illegal-word flag and a saturating illegal-word counter.
module dec_to_gray_enc #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [9:0]       Y,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             D,
    output logic             C,
    output logic             B,
    output logic             A,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             out_valid_r;
    logic [3:0]       dcba_r;
    logic             err_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             consume_s;
    logic [3:0]       code_s;
    logic             err_word_s;

    // Highest set line wins, so a multi-hot word still yields a usable code.
    function automatic logic [3:0] high_index(input logic [9:0] y);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (y[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] to_gray(input logic [3:0] bin);
        return bin ^ {1'b0, bin[3:1]};
    endfunction

    function automatic logic is_one_hot(input logic [9:0] y);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'b000, y[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Handshake decode and next-code computation.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        consume_s  = 1'b0;
        code_s     = 4'd0;
        err_word_s = 1'b0;

        in_ready_s = (!out_valid_r) | OUT_READY;
        accept_s   = IN_VALID & in_ready_s;
        consume_s  = out_valid_r & OUT_READY;
        code_s     = to_gray(high_index(Y));
        err_word_s = !is_one_hot(Y);
    end

    // Output register FSM and saturating error counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            dcba_r      <= 4'd0;
            err_r       <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        dcba_r      <= code_s;
                        err_r       <= err_word_s;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        dcba_r      <= code_s;
                        err_r       <= err_word_s;
                    end else if (consume_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase

            if (accept_s && err_word_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign IN_READY  = in_ready_s;
    assign D         = dcba_r[3];
    assign C         = dcba_r[2];
    assign B         = dcba_r[1];
    assign A         = dcba_r[0];
    assign OUT_VALID = out_valid_r;
    assign ERR       = err_r;
    assign ERR_CNT   = err_cnt_r;

endmodule

// File: tb/tb_dec_to_gray_enc.sv
// Directed bench for dec_to_gray_enc: vector table sweep plus stall, reset
// and counter-saturation sequences on a second CNT_W=2 instance.
module tb_dec_to_gray_enc;

    typedef struct {
        logic [9:0] y;
        logic [3:0] dcba;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [9:0] y;
    logic       in_valid;
    logic       in_ready;
    logic       d, c, b, a;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [7:0] err_cnt;

    logic [9:0] s_y;
    logic       s_in_valid;
    logic       s_in_ready;
    logic       s_d, s_c, s_b, s_a;
    logic       s_out_valid;
    logic       s_out_ready;
    logic       s_err;
    logic [1:0] s_err_cnt;

    int total;
    int bad;
    int exp_cnt;
    vec_t vecs[16];

    dec_to_gray_enc #(.CNT_W(8)) u_dut (
        .CLK(clk), .RST_N(rst_n), .Y(y), .IN_VALID(in_valid), .IN_READY(in_ready),
        .D(d), .C(c), .B(b), .A(a), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .ERR(err), .ERR_CNT(err_cnt)
    );

    dec_to_gray_enc #(.CNT_W(2)) u_sat (
        .CLK(clk), .RST_N(rst_n), .Y(s_y), .IN_VALID(s_in_valid), .IN_READY(s_in_ready),
        .D(s_d), .C(s_c), .B(s_b), .A(s_a), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
        .ERR(s_err), .ERR_CNT(s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] exp_dcba, input logic exp_err,
                             input logic exp_ov);
        check({name, " dcba"}, {28'd0, d, c, b, a}, {28'd0, exp_dcba});
        check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
        check({name, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 0;
        vecs[0]  = '{10'h001, 4'b0000, 1'b0};
        vecs[1]  = '{10'h002, 4'b0001, 1'b0};
        vecs[2]  = '{10'h004, 4'b0011, 1'b0};
        vecs[3]  = '{10'h008, 4'b0010, 1'b0};
        vecs[4]  = '{10'h010, 4'b0110, 1'b0};
        vecs[5]  = '{10'h020, 4'b0111, 1'b0};
        vecs[6]  = '{10'h040, 4'b0101, 1'b0};
        vecs[7]  = '{10'h080, 4'b0100, 1'b0};
        vecs[8]  = '{10'h100, 4'b1100, 1'b0};
        vecs[9]  = '{10'h200, 4'b1101, 1'b0};
        vecs[10] = '{10'h000, 4'b0000, 1'b1};
        vecs[11] = '{10'h081, 4'b0100, 1'b1};
        vecs[12] = '{10'h3FF, 4'b1101, 1'b1};
        vecs[13] = '{10'h003, 4'b0001, 1'b1};
        vecs[14] = '{10'h300, 4'b1101, 1'b1};
        vecs[15] = '{10'h004, 4'b0011, 1'b0};

        rst_n = 1'b0;
        y = 10'h000; in_valid = 1'b0; out_ready = 1'b0;
        s_y = 10'h000; s_in_valid = 1'b0; s_out_ready = 1'b0;
        #1;
        check_out("reset", 4'b0000, 1'b0, 1'b0);
        check("reset err_cnt", {24'd0, err_cnt}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream through the table, one word per cycle.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            y = vecs[i].y; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (vecs[i].err) exp_cnt++;
            check_out($sformatf("vec%0d", i), vecs[i].dcba, vecs[i].err, 1'b1);
            check($sformatf("vec%0d err_cnt", i), {24'd0, err_cnt}, exp_cnt);
            @(negedge clk);
        end

        // Stall: 0x010 held while 0x200 waits, then consume and accept on one edge.
        y = 10'h010; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        y = 10'h200; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check_out($sformatf("stall%0d", i), 4'b0110, 1'b0, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("stall release", 4'b1101, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out("consume only", 4'b1101, 1'b0, 1'b0);

        // Illegal word presented but never accepted must not count.
        @(negedge clk);
        y = 10'h000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_out("accept into empty", 4'b0000, 1'b1, 1'b1);
        exp_cnt++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stalled illegal cnt%0d", i), {24'd0, err_cnt}, exp_cnt);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consume keeps cnt", {24'd0, err_cnt}, exp_cnt);

        // Fresh reset, then illegal sequence 0x000, 0x081.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        y = 10'h000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("illegal zero", 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        y = 10'h081;
        @(posedge clk);
        #1;
        check_out("illegal 081", 4'b0100, 1'b1, 1'b1);
        check("illegal cnt", {24'd0, err_cnt}, 32'd2);

        // Async reset in FULL with DCBA=1101 and ERR_CNT=1.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        y = 10'h000;
        @(posedge clk);
        @(negedge clk);
        y = 10'h200;
        @(posedge clk);
        #1;
        check_out("pre-reset", 4'b1101, 1'b0, 1'b1);
        check("pre-reset cnt", {24'd0, err_cnt}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 4'b0000, 1'b0, 1'b0);
        check("async reset cnt", {24'd0, err_cnt}, 32'd0);
        y = 10'h000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("no accept in reset", 4'b0000, 1'b0, 1'b0);
        check("no count in reset", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        y = 10'h100;
        #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_out("first after reset", 4'b1100, 1'b0, 1'b1);

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        s_y = 10'h000; s_in_valid = 1'b1; s_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d", i), {30'd0, s_err_cnt}, (i < 3) ? i + 1 : 3);
            @(negedge clk);
        end
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
